// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared 640x480@60 raster constants, framebuffer defaults, the stored pixel
// layout and a constant-multiply helper used for framebuffer addressing.
// No ports (package).
package vga_timing_pkg;

  localparam logic [9:0] H_ACTIVE     = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;  // after 16-cycle front porch
  localparam logic [9:0] H_SYNC_END   = 10'd752;  // exclusive, 96-cycle pulse
  localparam logic [9:0] H_TOTAL      = 10'd800;  // 48-cycle back porch

  localparam logic [9:0] V_ACTIVE     = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;  // after 10-line front porch
  localparam logic [9:0] V_SYNC_END   = 10'd492;  // exclusive, 2-line pulse
  localparam logic [9:0] V_TOTAL      = 10'd525;  // 33-line back porch

  localparam int unsigned FB_W_DEFAULT = 160;
  localparam int unsigned FB_H_DEFAULT = 120;
  localparam int unsigned PIXEL_W      = 3;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } pixel_t;

  // Raster side-band carried alongside the memory read latency.
  typedef struct packed {
    logic hs;
    logic vs;
    logic slot;
  } align_t;

  localparam align_t ALIGN_IDLE = '{hs: 1'b1, vs: 1'b1, slot: 1'b0};

  // Multiply by a constant as a sum of shifted copies; with k constant this
  // reduces to a fixed adder tree rather than a multiplier.
  function automatic logic [31:0] mul_shift_add(input logic [31:0] x,
                                                input int unsigned k);
    logic [31:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + (x << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/vga_fb_scheduler_if.sv
// vga_fb_scheduler_if
// Writer handshake and single-port framebuffer bus.
//   slave  : the scheduler (takes wr_req/wr_addr/wr_data/mem_rdata,
//            drives wr_gnt/wr_err/mem_addr/mem_we/mem_wdata)
//   master : writer + memory side (the opposite directions)
interface vga_fb_scheduler_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned PIX_W  = 3
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_gnt;
  logic              wr_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata;

  modport slave (
    input  wr_req, wr_addr, wr_data, mem_rdata,
    output wr_gnt, wr_err, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_gnt, wr_err, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_raster_counter.sv
// vga_raster_counter
// 800x525 raster position counters and the undelayed timing decodes.
//   clock, reset_n : pixel clock, async active-low reset
//   h_cnt, v_cnt   : current raster position
//   hs_raw, vs_raw : active-low syncs for the current position
//   visible        : position is inside the 640x480 active area
//   frame_start    : high while the position is (0,0)
module vga_raster_counter
  import vga_timing_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       visible,
  output logic       frame_start
);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_TOTAL - 10'd1) begin
      h_d = '0;
      v_d = (v_q == V_TOTAL - 10'd1) ? '0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt   = h_q;
  assign v_cnt   = v_q;
  assign hs_raw  = !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
  assign vs_raw  = !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
  assign visible = (h_q < H_ACTIVE) && (v_q < V_ACTIVE);

  // Decoded from the counter flops so it is high on the very first cycle
  // after reset release; gated with reset_n so it stays low while in reset.
  assign frame_start = reset_n && (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_fb_scheduler.sv
// vga_fb_scheduler
// 640x480@60 raster timing plus single-port framebuffer arbitration between
// display read-out (owns the visible region) and a writer (blanking, or any
// time display_en=0). Sync and colour leave READ_LATENCY+1 cycles after the
// raster position that produced them.
//   clock, reset_n  : pixel clock, async active-low reset
//   display_en      : display owns memory in the visible region
//   bus (slave)     : writer handshake + framebuffer memory bus
//   frame_start     : pulse at raster (0,0), undelayed
//   vga_hsync/vsync : active-low syncs, aligned with colour
//   R, G, B         : 8-bit colour, full-scale per stored pixel bit
module vga_fb_scheduler
  import vga_timing_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned SCALE_SHIFT  = 2,
  parameter int unsigned FB_W         = FB_W_DEFAULT,
  parameter int unsigned FB_H         = FB_H_DEFAULT,
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned PIX_W        = PIXEL_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              display_en,
  vga_fb_scheduler_if.slave bus,
  output logic              frame_start,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B
);

  localparam int unsigned FB_CELLS = FB_W * FB_H;

  logic [9:0] h_cnt, v_cnt;
  logic       hs_raw, vs_raw, visible;

  vga_raster_counter u_raster (
    .clock       (clock),
    .reset_n     (reset_n),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .visible     (visible),
    .frame_start (frame_start)
  );

  logic              rd_slot, gnt, in_range;
  logic [9:0]        row, col;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              wr_err_q, wr_err_d;
  align_t            pipe_q [READ_LATENCY];
  align_t            pipe_d [READ_LATENCY];
  align_t            tail;
  logic              hs_q, hs_d, vs_q, vs_d;
  logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;

  assign rd_slot  = display_en && visible;
  assign row      = v_cnt >> SCALE_SHIFT;
  assign col      = h_cnt >> SCALE_SHIFT;
  assign rd_addr  = ADDR_W'(mul_shift_add(32'(row), FB_W) + 32'(col));
  assign gnt      = reset_n && bus.wr_req && !rd_slot;
  assign in_range = 32'(bus.wr_addr) < FB_CELLS;
  assign tail     = pipe_q[READ_LATENCY-1];

  always_comb begin
    mem_addr_d = mem_addr_q;
    if (rd_slot)  mem_addr_d = rd_addr;
    else if (gnt) mem_addr_d = bus.wr_addr;

    wr_err_d = wr_err_q || (gnt && !in_range);

    pipe_d[0] = '{hs: hs_raw, vs: vs_raw, slot: rd_slot};
    for (int unsigned i = 1; i < READ_LATENCY; i++) pipe_d[i] = pipe_q[i-1];

    hs_d = tail.hs;
    vs_d = tail.vs;
    r_d  = (tail.slot && bus.mem_rdata[PIX_W-1]) ? 8'hFF : 8'h00;
    g_d  = (tail.slot && bus.mem_rdata[PIX_W-2]) ? 8'hFF : 8'h00;
    b_d  = (tail.slot && bus.mem_rdata[PIX_W-3]) ? 8'hFF : 8'h00;
  end

  // The memory bus is combinational from the counters so mem_rdata lines up
  // with the last align stage; mem_addr_q only provides the idle hold value.
  always_comb begin
    bus.mem_addr  = mem_addr_d;
    bus.mem_we    = gnt && in_range;
    bus.mem_wdata = bus.wr_data;
    bus.wr_gnt    = gnt;
    bus.wr_err    = wr_err_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_q <= '0;
      wr_err_q   <= 1'b0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) pipe_q[i] <= ALIGN_IDLE;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      mem_addr_q <= mem_addr_d;
      wr_err_q   <= wr_err_d;
      pipe_q     <= pipe_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
    end
  end

  assign vga_hsync = hs_q;
  assign vga_vsync = vs_q;
  assign R         = r_q;
  assign G         = g_q;
  assign B         = b_q;

endmodule
